// File: rtl/oflow_mem_buffer_line_fetcher.sv
// Read-side client of the history memory buffer: issues line reads, holds each
// returned bbox pair and hands it to the similarity-metric stage with position tags.
module oflow_mem_buffer_line_fetcher #(
  parameter int DATA_WIDTH                  = 32,
  parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
  parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6,
  parameter int RD_LATENCY                  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_N,
  input  logic                                   fetch_start,
  input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
  input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
  output logic                                   start_read,
  output logic                                   read_new_line,
  input  logic [DATA_WIDTH-1:0]                  data_out_0,
  input  logic [DATA_WIDTH-1:0]                  data_out_1,
  output logic [DATA_WIDTH-1:0]                  line_data_0,
  output logic [DATA_WIDTH-1:0]                  line_data_1,
  output logic                                   line_valid,
  input  logic                                   line_ready,
  output logic                                   slot1_valid,
  output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] line_frame_idx,
  output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  line_bbox_idx,
  output logic                                   last_line,
  output logic                                   busy,
  output logic                                   fetch_done
);

  localparam int FW    = NUM_OF_HISTORY_FRAMES_WIDTH;
  localparam int BW    = NUM_OF_BBOX_IN_FRAME_WIDTH;
  localparam int LW    = BW + 1;
  localparam int LAT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    PRESENT   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [FW-1:0]    frames_q;
  logic [BW-1:0]    bbox_q;
  logic [LW-1:0]    lpf_q;
  logic [LW-1:0]    lpf_nxt;
  logic [LW-1:0]    line_in_frame;
  logic [LAT_W-1:0] lat_cnt;

  logic             accept;
  logic             counts_ok;
  logic             handshake;
  logic             lat_done;
  logic             frame_end;
  logic             last_frame;
  logic             tail_odd;

  logic             start_read_nxt;
  logic             read_new_line_nxt;
  logic             fetch_done_nxt;
  logic             busy_nxt;

  assign accept     = (state == IDLE) && fetch_start;
  assign counts_ok  = (|num_of_history_frames) && (|num_of_bbox_in_frame);
  assign handshake  = line_valid && line_ready;
  assign lat_done   = (lat_cnt == LAT_W'(1));
  assign lpf_nxt    = (LW'(num_of_bbox_in_frame) + LW'(1)) >> 1;
  // Each line covers two bboxes, so line_in_frame tracks line_bbox_idx / 2.
  assign frame_end  = (line_in_frame == lpf_q - LW'(1));
  assign last_frame = (line_frame_idx == frames_q - FW'(1));
  assign tail_odd   = bbox_q[0] && (line_bbox_idx == bbox_q - BW'(1));

  // State register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          state_nxt = counts_ok ? ISSUE : DONE;
        end
      end
      ISSUE:     state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (lat_done) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          state_nxt = last_line ? DONE : ISSUE;
        end
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered control outputs
  always_comb begin
    start_read_nxt    = (state == IDLE) && (state_nxt == ISSUE);
    read_new_line_nxt = (state == PRESENT) && (state_nxt == ISSUE);
    fetch_done_nxt    = (state_nxt == DONE);
    busy_nxt          = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      start_read    <= 1'b0;
      read_new_line <= 1'b0;
      fetch_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      start_read    <= start_read_nxt;
      read_new_line <= read_new_line_nxt;
      fetch_done    <= fetch_done_nxt;
      busy          <= busy_nxt;
    end
  end

  // Fetch geometry, position indices and read-latency counter
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      frames_q       <= '0;
      bbox_q         <= '0;
      lpf_q          <= '0;
      line_frame_idx <= '0;
      line_bbox_idx  <= '0;
      line_in_frame  <= '0;
      lat_cnt        <= '0;
    end else begin
      if (accept) begin
        frames_q       <= num_of_history_frames;
        bbox_q         <= num_of_bbox_in_frame;
        lpf_q          <= lpf_nxt;
        line_frame_idx <= '0;
        line_bbox_idx  <= '0;
        line_in_frame  <= '0;
      end else if ((state == PRESENT) && handshake && !last_line) begin
        if (frame_end) begin
          line_bbox_idx  <= '0;
          line_in_frame  <= '0;
          line_frame_idx <= line_frame_idx + FW'(1);
        end else begin
          line_bbox_idx  <= line_bbox_idx + BW'(2);
          line_in_frame  <= line_in_frame + LW'(1);
        end
      end

      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(RD_LATENCY);
      end else if (state == WAIT_DATA) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

  // Holding register for the returned pair and its line tags
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      line_data_0 <= '0;
      line_data_1 <= '0;
      line_valid  <= 1'b0;
      slot1_valid <= 1'b0;
      last_line   <= 1'b0;
    end else begin
      if ((state == WAIT_DATA) && lat_done) begin
        line_data_0 <= data_out_0;
        line_data_1 <= data_out_1;
        line_valid  <= 1'b1;
        slot1_valid <= !tail_odd;
        last_line   <= last_frame && frame_end;
      end else if ((state == PRESENT) && handshake) begin
        line_valid  <= 1'b0;
        slot1_valid <= 1'b0;
        last_line   <= 1'b0;
      end
    end
  end

endmodule
